// File: rtl/main_mem_ctrl.sv
// Main-memory model behind the cache FSM: fixed-latency block refill reads and word write-through.
// Optional MAIN_MEM_STATS_EN adds saturating rd_count/wr_count completion counters.
module main_mem_ctrl #(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int LATENCY         = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              main_read,
  input  logic                              main_write,
  input  logic [ADDR_W-1:0]                 addr,
  input  logic [DATA_W-1:0]                 wdata,
  output logic [DATA_W*WORDS_PER_BLOCK-1:0] rdata_block,
  output logic                              ready,
  output logic                              busy
`ifdef MAIN_MEM_STATS_EN
  ,
  output logic [15:0]                       rd_count,
  output logic [15:0]                       wr_count
`endif
);

  // state  | meaning
  // IDLE   | waiting for main_read / main_write
  // ACCESS | counting down the access latency on latched request
  // DONE   | access performed, ready high, requests ignored
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int CNT_W = ($clog2(LATENCY) + 1 > 4) ? $clog2(LATENCY) + 1 : 4;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                op_read;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [ADDR_W-1:0]   base;
  logic                accept;
  logic                do_access;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (main_read || main_write) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == IDLE) && (main_read || main_write);
    do_access = (state == ACCESS) && (cnt == '0);
    ready     = (state == DONE);
    busy      = (state != IDLE);
  end

  assign base = lat_addr & ~ADDR_W'(WORDS_PER_BLOCK - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      op_read     <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rdata_block <= '0;
    end else begin
      if (accept) begin
        op_read   <= main_read;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        cnt       <= CNT_W'(LATENCY - 1);
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (do_access && op_read) begin
        for (int i = 0; i < WORDS_PER_BLOCK; i++)
          rdata_block[DATA_W*i +: DATA_W] <= mem[ADDR_W'(base + ADDR_W'(i))];
      end
    end
  end

  // Memory is never cleared; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!reset && do_access && !op_read)
      mem[lat_addr] <= lat_wdata;
  end

`ifdef MAIN_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (do_access) begin
      if (op_read && rd_count != 16'hFFFF)  rd_count <= rd_count + 16'd1;
      if (!op_read && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/main_mem_ctrl.md
# main_mem_ctrl

Main-memory model and controller sitting directly downstream of the cache controller FSM. It accepts the FSM's `main_read` (block refill) and `main_write` (write-through word) requests and services them after a fixed access latency. It returns a one-cycle `ready` pulse to the FSM, and for reads it presents the full refill block to the cache data array.

## Interface

Parameters:
- `ADDR_W`, 10, word-address width; memory depth is 2^ADDR_W words.
- `DATA_W`, 32, word width.
- `WORDS_PER_BLOCK`, 4, words per cache block; power of two, ≥1.
- `LATENCY`, 4, cycles from request acceptance to `ready`; ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `main_read`  in  1  block read request, held until `ready`.
- `main_write`  in  1  word write request, held until `ready`.
- `addr`  in  ADDR_W  word address of the request.
- `wdata`  in  DATA_W  write data.
- `rdata_block`  out  DATA_W*WORDS_PER_BLOCK  refill block; word i at `[DATA_W*i +: DATA_W]`.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation

- States: IDLE, ACCESS, DONE. 4-bit-or-wider down-counter `cnt` (width `$clog2(LATENCY)+1`).
- IDLE transitions:
  - `main_read` → ACCESS, op=READ.
  - else `main_write` → ACCESS, op=WRITE.
  - On either, latch `addr`, `wdata` and op, and load `cnt <= LATENCY-1`.
  - Read has priority if both requests are high.
- ACCESS transitions:
  - `cnt != 0`: `cnt <= cnt-1`.
  - `cnt == 0`: perform the access and go to DONE.
  - READ access: `rdata_block` word i <= `mem[base+i]`, where base = latched addr with the low `log2(WORDS_PER_BLOCK)` bits cleared.
  - WRITE access: `mem[latched addr] <= latched wdata`; `rdata_block` is unchanged.
- DONE → IDLE unconditionally. Requests are ignored in DONE, which gives one turnaround cycle.
- `ready` is registered and high exactly while the state is DONE.
- The access uses only the latched values:
  - Changes on `addr`/`wdata` after acceptance have no effect.
  - Dropping a request mid-ACCESS does not abort it; the access completes and `ready` still pulses.
- `rdata_block` holds its value until the next READ completes.
- Block reads never cross a block boundary; addresses wrap modulo 2^ADDR_W (cannot occur when base is aligned).
- Reset values:
  - Outputs: `ready`=0, `busy`=0, `rdata_block`=0.
  - Internal: state=IDLE, `cnt`=0.
  - Memory array contents are not cleared.
- Reset mid-operation abandons the access. A WRITE in ACCESS does not write memory, and no `ready` is issued.

## Timing

- Request sampled high in IDLE at edge E0. `ready` is high during the cycle following edge E0+LATENCY, for exactly one cycle.
- The memory write and the `rdata_block` update occur at edge E0+LATENCY, so `rdata_block` is valid in the same cycle `ready` is high.
- The requester deasserts its request in the `ready` cycle. The FSM does so combinationally from `ready`.
- A request still high after DONE is accepted as a new request at the first IDLE edge.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- `busy` rises the cycle after acceptance and falls the cycle after `ready`.

## Configuration

- `MAIN_MEM_STATS_EN` defined:
  - Adds output `rd_count` (16 bits), which increments on each completed READ.
  - Adds output `wr_count` (16 bits), which increments on each completed WRITE.
  - Both counters increment at the DONE-entry edge, saturate at 16'hFFFF, and reset to 0.
- `MAIN_MEM_STATS_EN` undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan

- Reset with default parameters:
  - Preload `mem[8..11]` = 0xA0..0xA3.
  - Stimulus: hold `main_read` with addr=10.
  - Required: `ready` high for exactly 1 cycle, 4 cycles after acceptance.
  - Required: `rdata_block` = {0xA3,0xA2,0xA1,0xA0}.
- Write, then read back:
  - Stimulus: `main_write` with addr=5, wdata=0xDEADBEEF, then `main_read` with addr=4.
  - Required: `ready` pulses for each access.
  - Required: word 1 of `rdata_block` = 0xDEADBEEF; words 0, 2 and 3 hold their previous memory values.
- Simultaneous requests:
  - Stimulus: `main_read` and `main_write` high together in IDLE.
  - Required: the read is serviced, memory is unmodified, and the write is accepted after DONE if still held.
- Input change and early drop:
  - Stimulus: change `addr`/`wdata` mid-ACCESS, and drop `main_write` after 1 cycle.
  - Required: the original latched write lands, and `ready` still pulses once.
- Reset mid-access:
  - Stimulus: assert `reset` 2 cycles into a WRITE to addr=3.
  - Required: `mem[3]` unchanged, no `ready`, `busy`=0 the next cycle.
  - Required: a new read afterwards completes normally.
- Statistics (`MAIN_MEM_STATS_EN` defined):
  - Stimulus: 3 reads and 2 writes.
  - Required: `rd_count`=3, `wr_count`=2.
  - Required after reset: both counters = 0.
